// File: rtl/sha2_k_sequencer.sv
// rtl/sha2_k_sequencer.sv - SHA-2 round-constant sequencer (K256/K512) with valid/ready output
// One shared 64-bit table; the 32-bit schedule takes the upper halves of the first 64 entries.
module sha2_k_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         chain,
  input  logic         abort,
  input  logic         k_ready,
  output logic         k_valid,
  output logic [W-1:0] k_out,
  output logic [6:0]   round_out,
  output logic         last,
  output logic         busy
);

  localparam int ROUNDS = (W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("sha2_k_sequencer: W must be 32 or 64");
  end

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic           k_valid_q, k_valid_d;
  logic [W-1:0]   k_out_q, k_out_d;
  logic [6:0]     round_q, round_d;
  logic           last_q, last_d;
  logic           load;
  logic [6:0]     load_idx;
  logic           hs;

  assign hs = k_valid_q & k_ready;

  // Every path into RUN goes through 'load', so outputs are zero whenever k_valid is low.
  always_comb begin
    state_d   = state_q;
    k_valid_d = k_valid_q;
    k_out_d   = k_out_q;
    round_d   = round_q;
    last_d    = last_q;
    load      = 1'b0;
    load_idx  = 7'd0;
    if (abort) begin
      state_d   = IDLE;
      k_valid_d = 1'b0;
      k_out_d   = '0;
      round_d   = 7'd0;
      last_d    = 1'b0;
    end else if (start) begin
      load = 1'b1;
    end else if (state_q == RUN && hs) begin
      if (round_q == LAST_ROUND) begin
        if (chain) begin
          load = 1'b1;
        end else begin
          state_d   = IDLE;
          k_valid_d = 1'b0;
          k_out_d   = '0;
          round_d   = 7'd0;
          last_d    = 1'b0;
        end
      end else begin
        load     = 1'b1;
        load_idx = round_q + 7'd1;
      end
    end
    if (load) begin
      state_d   = RUN;
      k_valid_d = 1'b1;
      round_d   = load_idx;
      k_out_d   = K512[load_idx][63 -: W];
      last_d    = (load_idx == LAST_ROUND);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_valid_q <= 1'b0;
      k_out_q   <= '0;
      round_q   <= 7'd0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_valid_q <= k_valid_d;
      k_out_q   <= k_out_d;
      round_q   <= round_d;
      last_q    <= last_d;
    end
  end

  assign k_valid   = k_valid_q;
  assign k_out     = k_out_q;
  assign round_out = round_q;
  assign last      = last_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// tb/tb_sha2_k_sequencer.sv - scoreboard bench for sha2_k_sequencer, W=32 and W=64 side by side
// Both instances share stimulus; each has its own queue of expected constants.
module tb_sha2_k_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, chain, abort, k_ready;
  logic        v32, b32, l32, v64, b64, l64;
  logic [31:0] k32;
  logic [63:0] k64;
  logic [6:0]  r32, r64;

  sha2_k_sequencer #(.W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .chain(chain), .abort(abort), .k_ready(k_ready),
    .k_valid(v32), .k_out(k32), .round_out(r32), .last(l32), .busy(b32)
  );

  sha2_k_sequencer #(.W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start), .chain(chain), .abort(abort), .k_ready(k_ready),
    .k_valid(v64), .k_out(k64), .round_out(r64), .last(l64), .busy(b64)
  );

  logic [63:0] tbl [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef struct {
    logic [6:0]  r;
    logic [63:0] k;
    logic        l;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   errors = 0;
  int   n32 = 0;
  int   n64 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.r = 7'(i); e.k = {32'd0, tbl[i][63:32]}; e.l = (i == 63);
      q32.push_back(e);
    end
    for (int i = 0; i < 80; i++) begin
      e.r = 7'(i); e.k = tbl[i]; e.l = (i == 79);
      q64.push_back(e);
    end
  endtask

  task automatic obs_check(input string tag, input logic v, input logic b, input logic [6:0] r,
                           input logic [63:0] k, input logic l, input logic have, input exp_t e);
    check({tag, "_busy"}, 64'(b), 64'(v));
    if (v) begin
      check({tag, "_expected_pending"}, 64'(have), 64'd1);
      if (have) begin
        check({tag, "_round"}, 64'(r), 64'(e.r));
        check({tag, "_k"}, k, e.k);
        check({tag, "_last"}, 64'(l), 64'(e.l));
      end
    end else begin
      check({tag, "_idle_round"}, 64'(r), 64'd0);
      check({tag, "_idle_k"}, k, 64'd0);
      check({tag, "_idle_last"}, 64'(l), 64'd0);
    end
  endtask

  // Call with inputs already set for the coming rising edge; returns at the following falling edge.
  task automatic cyc();
    logic        gate, stall;
    logic [31:0] pk;
    logic [6:0]  pr;
    exp_t        e;
    gate  = rst_n && !abort && !start;
    stall = gate && v32 && !k_ready;
    pk    = k32;
    pr    = r32;
    if (gate && v32 && k_ready && q32.size() > 0) void'(q32.pop_front());
    if (gate && v64 && k_ready && q64.size() > 0) void'(q64.pop_front());
    @(negedge clk);
    e = '{r: 7'd0, k: 64'd0, l: 1'b0};
    if (q32.size() > 0) e = q32[0];
    obs_check("w32", v32, b32, r32, {32'd0, k32}, l32, q32.size() > 0, e);
    e = '{r: 7'd0, k: 64'd0, l: 1'b0};
    if (q64.size() > 0) e = q64[0];
    obs_check("w64", v64, b64, r64, k64, l64, q64.size() > 0, e);
    if (stall) begin
      check("stall_k_stable", {32'd0, k32}, {32'd0, pk});
      check("stall_round_stable", 64'(r32), 64'(pr));
    end
    if (v32) n32++;
    if (v64) n64++;
  endtask

  task automatic do_start();
    start = 1'b1;
    q32.delete();
    q64.delete();
    push_all();
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    q32.delete();
    q64.delete();
    cyc();
    abort = 1'b0;
    check("abort_valid32", 64'(v32), 64'd0);
    check("abort_valid64", 64'(v64), 64'd0);
    check("abort_k32", {32'd0, k32}, 64'd0);
  endtask

  task automatic run_to_round(input int target, input string tag);
    for (int i = 0; i < 120 && !(v32 && r32 == 7'(target)); i++) cyc();
    check(tag, 64'(v32 && r32 == 7'(target)), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; chain = 1'b0; abort = 1'b0; k_ready = 1'b0;
    cyc();
    cyc();
    check("reset_valid32", 64'(v32), 64'd0);
    check("reset_busy64", 64'(b64), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Full-speed run: 64 constants from the 32-bit instance, 80 from the 64-bit one.
    k_ready = 1'b1;
    n32 = 0; n64 = 0;
    do_start();
    check("first_k32", {32'd0, k32}, 64'h428a2f98);
    check("first_k64", k64, 64'h428a2f98d728ae22);
    for (int i = 0; i < 200 && (q32.size() > 0 || q64.size() > 0); i++) cyc();
    check("full_drain", 64'(q32.size() + q64.size()), 64'd0);
    check("full_count32", 64'(n32), 64'd64);
    check("full_count64", 64'(n64), 64'd80);
    check("full_end_valid32", 64'(v32), 64'd0);
    check("full_end_valid64", 64'(v64), 64'd0);
    cyc();

    // Random consumer stalls.
    do_start();
    for (int i = 0; i < 600 && q32.size() > 0; i++) begin
      k_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    check("stall_drain32", 64'(q32.size()), 64'd0);
    k_ready = 1'b1;
    do_abort();

    // Chained blocks: last handshake with chain=1 wraps to round 0 without a gap.
    do_start();
    for (int i = 0; i < 100 && q32.size() > 1; i++) cyc();
    check("chain_at_last", 64'(l32), 64'd1);
    chain = 1'b1;
    push_all();
    for (int i = 0; i < 16; i++) void'(q64.pop_back());
    cyc();
    chain = 1'b0;
    check("chain_valid", 64'(v32), 64'd1);
    check("chain_round", 64'(r32), 64'd0);
    check("chain_k", {32'd0, k32}, 64'h428a2f98);
    check("chain_busy", 64'(b32), 64'd1);
    cyc();
    cyc();
    do_abort();

    // Restart mid-sequence, with a handshake in the same cycle.
    do_start();
    run_to_round(20, "reach_round20");
    do_start();
    check("restart_round", 64'(r32), 64'd0);
    check("restart_k", {32'd0, k32}, 64'h428a2f98);
    check("restart_valid", 64'(v32), 64'd1);

    // Abort mid-sequence.
    run_to_round(30, "reach_round30");
    do_abort();
    cyc();

    // Reset mid-sequence; start and abort held during reset are ignored.
    do_start();
    run_to_round(40, "reach_round40");
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    q32.delete();
    q64.delete();
    cyc();
    check("rst_valid32", 64'(v32), 64'd0);
    check("rst_k64", k64, 64'd0);
    check("rst_round32", 64'(r32), 64'd0);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    cyc();
    check("post_rst_idle", 64'(v32), 64'd0);
    do_start();
    check("post_rst_round", 64'(r32), 64'd0);
    check("post_rst_k", {32'd0, k32}, 64'h428a2f98);
    do_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_k_sequencer.md
SHA2_K_SEQUENCER -- requirements
Module: sha2_k_sequencer

Interface
REQ-001 Parameter W, default 32, meaning word width; 32 selects the SHA-224/256 schedule (64 rounds), 64 selects the SHA-384/512 schedule (80 rounds).
REQ-002 Derived localparam ROUNDS = 64 when W=32, 80 when W=64; any other W SHALL cause an elaboration error.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  pulse; begins a new constant sequence at round 0.
REQ-006 chain  input  1  level; sampled at the last-round handshake; 1 = wrap to round 0 for the next message block without going idle.
REQ-007 abort  input  1  pulse; terminates the current sequence.
REQ-008 k_ready  input  1  consumer accepts the current constant.
REQ-009 k_valid  output  1  k_out holds a valid round constant.
REQ-010 k_out  output  W  round constant K[round].
REQ-011 round_out  output  7  index of the constant on k_out.
REQ-012 last  output  1  high with k_valid when round_out = ROUNDS-1.
REQ-013 busy  output  1  high in state RUN.

Function
REQ-014 The block SHALL hold one 80-entry x 64-bit constant table (FIPS 180-4 K512); for W=32, K[i] = K512[i][63:32], i = 0..63; for W=64, K[i] = K512[i], i = 0..79.
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE, start=1 -> RUN; on the next cycle k_valid=1, round_out=0, k_out=K[0].
REQ-017 The handshake SHALL be k_valid & k_ready; on a handshake with round_out < ROUNDS-1, round_out increments by 1 and k_out = K[round_out+1] on the next cycle.
REQ-018 When k_valid=1 and k_ready=0, k_out, round_out and last SHALL hold stable.
REQ-019 On a handshake at round_out = ROUNDS-1 with chain=0, the block SHALL go to IDLE; on the next cycle k_valid=0.
REQ-020 On a handshake at round_out = ROUNDS-1 with chain=1, the block SHALL stay in RUN with round_out=0 and k_out=K[0] on the next cycle, with no bubble.
REQ-021 start in RUN SHALL restart the sequence: next cycle round_out=0, k_out=K[0], k_valid=1, regardless of any handshake that cycle.
REQ-022 abort in any state SHALL force IDLE on the next cycle with k_valid=0.
REQ-023 Priority SHALL be: rst_n > abort > start > handshake.
REQ-024 Whenever k_valid=0, k_out, round_out and last SHALL all be 0.
REQ-025 Outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-026 Sustained throughput SHALL be one constant per cycle while k_ready=1; latency from start to the first valid is 1 cycle.
REQ-027 round_out SHALL never exceed ROUNDS-1; there is no wrap other than the one in REQ-020.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE with k_valid=0, k_out=0, round_out=0, last=0 and busy=0.
REQ-029 Reset asserted mid-sequence SHALL discard progress; the first start after reset SHALL begin at K[0].
REQ-030 The block SHALL ignore start, abort and k_ready while rst_n=0.

Verification
REQ-031 W=32, start, k_ready=1 held -> 64 consecutive valids, K[0]=428a2f98, K[1]=71374491, K[63]=c67178f2 with last=1, then k_valid=0.
REQ-032 W=64, start, k_ready=1 held -> 80 valids, K[0]=428a2f98d728ae22, K[63]=c67178f2e372532b, K[79]=6c44198c4a475817 with last=1.
REQ-033 W=32, random k_ready stalls -> k_out stable during each stall; the accepted sequence matches the FIPS 180-4 table in order.
REQ-034 W=32, chain=1 at the last handshake -> the next cycle shows round_out=0, k_out=428a2f98, busy=1, with no k_valid gap.
REQ-035 start asserted at round 20 (and abort at round 30 on a separate run) -> start restarts at 428a2f98, round_out=0; abort gives k_valid=0, k_out=0 on the next cycle.
REQ-036 rst_n=0 for one cycle at round 40 -> all outputs 0 on the next cycle; a following start yields K[0].
